// File: rtl/dot_p_pkg.sv
// Shared types and width helpers for the sequential dot-product array.
package dot_p_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Accumulator width that holds n products of two fp-bit operands without overflow.
  function automatic int unsigned acc_width(input int unsigned fp, input int unsigned n);
    return 2 * fp + $clog2(n);
  endfunction

endpackage

// File: rtl/dot_p_lane.sv
// One multiply-accumulate lane: selects its coefficient by element index,
// loads or accumulates the product, and narrows the accumulator to FP_SIZE.
// Optional feature: define DOT_P_SAT_EN to saturate instead of truncate.
module dot_p_lane
  import dot_p_pkg::*;
#(
  parameter int unsigned FP_SIZE  = 64,
  parameter int unsigned PC_NUM   = 32,
  parameter int unsigned ACC_SIZE = acc_width(FP_SIZE, PC_NUM),
  parameter int unsigned CNT_W    = $clog2(PC_NUM)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             first_i,
  input  logic                             accum_i,
  input  logic [CNT_W-1:0]                 sel_i,
  input  logic [PC_NUM-1:0][FP_SIZE-1:0]   coef_row_i,
  input  logic [FP_SIZE-1:0]               data_i,
  output logic [FP_SIZE-1:0]               out_o
);

  localparam int unsigned PROD_W = 2 * FP_SIZE;

  logic [FP_SIZE-1:0]  coef_sel_c;
  logic [PROD_W-1:0]   prod_c;
  logic [ACC_SIZE-1:0] acc_q, acc_d;

  assign coef_sel_c = coef_row_i[sel_i];
  assign prod_c     = PROD_W'(coef_sel_c) * PROD_W'(data_i);

  // First element overwrites the accumulator; later elements add to it.
  always_comb begin
    acc_d = acc_q;
    if (first_i) begin
      acc_d = ACC_SIZE'(prod_c);
    end else if (accum_i) begin
      acc_d = acc_q + ACC_SIZE'(prod_c);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Narrow the accumulator to the output width.
  always_comb begin
`ifdef DOT_P_SAT_EN
    out_o = (|acc_q[ACC_SIZE-1:FP_SIZE]) ? '1 : acc_q[FP_SIZE-1:0];
`else
    out_o = acc_q[FP_SIZE-1:0];
`endif
  end

endmodule

// File: rtl/seq_dot_p_array.sv
// Streaming MIN_PC_NUM x PC_NUM projection array: coefficient bank, element
// counter and IDLE/ACCUM/HOLD control, feeding MIN_PC_NUM MAC lanes.
// Optional feature: define DOT_P_SAT_EN to saturate outputs instead of truncating.
module seq_dot_p_array
  import dot_p_pkg::*;
#(
  parameter int unsigned FP_SIZE    = 64,
  parameter int unsigned PC_NUM     = 32,
  parameter int unsigned MIN_PC_NUM = 5,
  parameter int unsigned ACC_SIZE   = acc_width(FP_SIZE, PC_NUM),
  localparam int unsigned ROW_W     = (MIN_PC_NUM > 1) ? $clog2(MIN_PC_NUM) : 1,
  localparam int unsigned CNT_W     = $clog2(PC_NUM)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 coef_we,
  input  logic [ROW_W-1:0]                     coef_row,
  input  logic [CNT_W-1:0]                     coef_col,
  input  logic [FP_SIZE-1:0]                   coef_data,
  output logic                                 coef_ready,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FP_SIZE-1:0]                   in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [0:MIN_PC_NUM-1][FP_SIZE-1:0]   out_vector,
  output logic                                 busy
);

  state_t                                        state_q, state_d;
  logic [CNT_W-1:0]                              cnt_q, cnt_d;
  logic [MIN_PC_NUM-1:0][PC_NUM-1:0][FP_SIZE-1:0] coef_q, coef_d;
  logic                                          accept_c;
  logic                                          first_c;
  logic                                          accum_c;

  // Status decoded purely from the state register.
  assign in_ready   = (state_q != HOLD);
  assign coef_ready = (state_q != ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);

  assign accept_c = in_valid && in_ready;
  assign first_c  = accept_c && (state_q == IDLE);
  assign accum_c  = accept_c && (state_q == ACCUM);

  // Next-state and element counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = ACCUM;
          cnt_d   = CNT_W'(1);
        end
      end
      ACCUM: begin
        if (accept_c) begin
          if (cnt_q == CNT_W'(PC_NUM - 1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Coefficient writes are taken only outside ACCUM and only for in-range indices.
  always_comb begin
    coef_d = coef_q;
    if (coef_we && coef_ready && (32'(coef_row) < MIN_PC_NUM) && (32'(coef_col) < PC_NUM)) begin
      coef_d[coef_row][coef_col] = coef_data;
    end
  end

  // Control and coefficient bank registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coef_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coef_q  <= coef_d;
    end
  end

  // One MAC lane per projection.
  for (genvar g = 0; g < MIN_PC_NUM; g++) begin : g_lane
    dot_p_lane #(
      .FP_SIZE  (FP_SIZE),
      .PC_NUM   (PC_NUM),
      .ACC_SIZE (ACC_SIZE),
      .CNT_W    (CNT_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .first_i    (first_c),
      .accum_i    (accum_c),
      .sel_i      (cnt_q),
      .coef_row_i (coef_q[g]),
      .data_i     (in_data),
      .out_o      (out_vector[g])
    );
  end

endmodule

// File: tb/tb_seq_dot_p_array.sv
// Self-checking bench for seq_dot_p_array (FP_SIZE=8, PC_NUM=4, MIN_PC_NUM=2).
module tb_seq_dot_p_array;

  localparam int FP = 8;
  localparam int PC = 4;
  localparam int MP = 2;

  logic                      clk;
  logic                      reset;
  logic                      coef_we;
  logic [0:0]                coef_row;
  logic [1:0]                coef_col;
  logic [FP-1:0]             coef_data;
  logic                      coef_ready;
  logic                      in_valid;
  logic                      in_ready;
  logic [FP-1:0]             in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [0:MP-1][FP-1:0]     out_vector;
  logic                      busy;

  int errors = 0;
  int checks = 0;

  logic [FP-1:0] coef_m [MP][PC];
  logic [FP-1:0] vec    [PC];

  seq_dot_p_array #(
    .FP_SIZE    (FP),
    .PC_NUM     (PC),
    .MIN_PC_NUM (MP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coef_we    (coef_we),
    .coef_row   (coef_row),
    .coef_col   (coef_col),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vector (out_vector),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision dot product, then narrowed to FP bits.
  function automatic logic [FP-1:0] model_lane(input int r);
    longint unsigned sum;
    sum = 0;
    for (int j = 0; j < PC; j++) sum += 64'(coef_m[r][j]) * 64'(vec[j]);
`ifdef DOT_P_SAT_EN
    if (sum > 64'd255) return 8'hFF;
`endif
    return FP'(sum);
  endfunction

  task automatic write_coef(input int r, input int c, input logic [FP-1:0] d);
    coef_we = 1'b1; coef_row = 1'(r); coef_col = 2'(c); coef_data = d;
    @(posedge clk); @(negedge clk);
    coef_we = 1'b0;
    coef_m[r][c] = d;
  endtask

  task automatic load_rows(input logic [FP-1:0] r0 [PC], input logic [FP-1:0] r1 [PC]);
    for (int j = 0; j < PC; j++) write_coef(0, j, r0[j]);
    for (int j = 0; j < PC; j++) write_coef(1, j, r1[j]);
  endtask

  task automatic load_random_coefs();
    for (int r = 0; r < MP; r++)
      for (int j = 0; j < PC; j++) write_coef(r, j, FP'($urandom_range(255, 1)));
  endtask

  // Streams vec, optionally with bubbles, a dropped write mid-ACCUM and a write in HOLD.
  task automatic run_vector(input string name, input int gap_max, input int hold_cycles,
                            input int lock_at, input bit hold_write);
    logic [FP-1:0] exp [MP];
    for (int r = 0; r < MP; r++) exp[r] = model_lane(r);
    for (int i = 0; i < PC; i++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (i > 0 && out_valid !== 1'b0) begin
          errors++; $display("FAIL %s bubble out_valid: got %b want 0", name, out_valid);
        end
      end
      in_valid = 1'b1; in_data = vec[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL %s in_ready elem %0d: got %b want 1", name, i, in_ready);
      end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL %s busy elem %0d: got %b want 1", name, i, busy);
      end
      if (i < PC - 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL %s early out_valid elem %0d: got %b want 0", name, i, out_valid);
        end
      end
      if (i == lock_at) begin
        checks++;
        if (coef_ready !== 1'b0) begin
          errors++; $display("FAIL %s coef_ready in ACCUM: got %b want 0", name, coef_ready);
        end
        coef_we = 1'b1; coef_row = 1'b0; coef_col = 2'd0; coef_data = 8'd9;
        @(posedge clk); @(negedge clk);
        coef_we = 1'b0;
      end
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s hold entry: out_valid=%b in_ready=%b want 1/0", name, out_valid, in_ready);
    end
    for (int r = 0; r < MP; r++) begin
      checks++;
      if (out_vector[r] !== exp[r]) begin
        errors++; $display("FAIL %s lane %0d: got %0d want %0d", name, r, out_vector[r], exp[r]);
      end
    end
    if (hold_write) begin
      checks++;
      if (coef_ready !== 1'b1) begin
        errors++; $display("FAIL %s coef_ready in HOLD: got %b want 1", name, coef_ready);
      end
      write_coef(0, 0, 8'd9);
    end
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vector[0] !== exp[0] || out_vector[1] !== exp[1]) begin
        errors++;
        $display("FAIL %s hold cycle %0d: valid=%b ready=%b out=%0d,%0d want 1/0 %0d,%0d",
                 name, h, out_valid, in_ready, out_vector[0], out_vector[1], exp[0], exp[1]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s return to idle: valid=%b busy=%b in_ready=%b want 0/0/1", name, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; coef_we = 1'b0; coef_row = '0; coef_col = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int r = 0; r < MP; r++) for (int j = 0; j < PC; j++) coef_m[r][j] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || coef_ready !== 1'b1 || out_vector !== '0) begin
      errors++;
      $display("FAIL reset state: valid=%b busy=%b coef_ready=%b out=%h", out_valid, busy, coef_ready, out_vector);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [FP-1:0] r0 [PC];
    logic [FP-1:0] r1 [PC];
    r0 = '{8'd1, 8'd2, 8'd3, 8'd4};
    r1 = '{8'd0, 8'd0, 8'd0, 8'd1};
    load_rows(r0, r1);
    vec = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_vector("basic", 0, 0, -1, 1'b0);
  endtask

  task automatic test_narrowing();
    logic [FP-1:0] r [PC];
    r = '{8'd255, 8'd255, 8'd255, 8'd255};
    load_rows(r, r);
    vec = '{8'd255, 8'd255, 8'd255, 8'd255};
    run_vector("narrowing", 0, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) begin
      load_random_coefs();
      for (int j = 0; j < PC; j++) vec[j] = FP'($urandom_range(255, 0));
      run_vector("backpressure", 3, 5, -1, 1'b0);
    end
  endtask

  task automatic test_lockout();
    load_random_coefs();
    for (int j = 0; j < PC; j++) vec[j] = FP'($urandom_range(255, 1));
    run_vector("lockout_accum", 1, 1, 1, 1'b1);
    for (int j = 0; j < PC; j++) vec[j] = FP'($urandom_range(255, 1));
    run_vector("lockout_next", 0, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    load_random_coefs();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = FP'($urandom_range(255, 1));
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (out_vector !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || coef_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid outputs: out=%h valid=%b busy=%b coef_ready=%b", out_vector, out_valid, busy, coef_ready);
    end
    for (int r = 0; r < MP; r++) for (int j = 0; j < PC; j++) coef_m[r][j] = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int j = 0; j < PC; j++) vec[j] = FP'($urandom_range(255, 1));
    run_vector("reset_mid_cleared", 0, 0, -1, 1'b0);
    load_random_coefs();
    for (int j = 0; j < PC; j++) vec[j] = FP'($urandom_range(255, 0));
    run_vector("reset_mid_reload", 0, 0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [FP-1:0] r0 [PC];
    logic [FP-1:0] r1 [PC];
    r0 = '{8'd1, 8'd2, 8'd3, 8'd4};
    r1 = '{8'd0, 8'd0, 8'd0, 8'd1};
    load_rows(r0, r1);
    vec = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_vector("b2b_first", 0, 0, -1, 1'b0);
    vec = '{8'd2, 8'd0, 8'd0, 8'd0};
    run_vector("b2b_second", 0, 0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_narrowing();
    test_backpressure();
    test_lockout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
